axi_write_slave: RTL

AXI_WRITE_SLAVE -- requirements
Module: axi_write_slave

---
 rtl/axi_write_slave_pkg.sv | 32 +++
 rtl/axi_write_slave_skid.sv | 60 ++++++
 rtl/axi_write_slave.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_write_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_write_slave_pkg
// Description : Shared constants for the AXI write slave: FSM state codes,
//               BRESP codes, AXI burst codes and a burst-legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_write_slave_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t C_ST_IDLE = 2'd0;
  localparam state_t C_ST_DATA = 2'd1;
  localparam state_t C_ST_RESP = 2'd2;

  // Write response codes
  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;

  // AXI burst type codes (2'b11 is reserved)
  localparam logic [1:0] C_BURST_FIXED = 2'b00;
  localparam logic [1:0] C_BURST_INCR  = 2'b01;
  localparam logic [1:0] C_BURST_WRAP  = 2'b10;

  // Only FIXED and INCR bursts reach the local memory; WRAP and the
  // reserved code are drained and answered with SLVERR.
  function automatic logic burst_writes(input logic [1:0] burst);
    return (burst == C_BURST_FIXED) || (burst == C_BURST_INCR);
  endfunction

endpackage : axi_write_slave_pkg
`default_nettype wire

// File: rtl/axi_write_slave_skid.sv
`default_nettype none
// ============================================================================
// Module      : axi_write_slave_skid
// Description : One-beat holding buffer for a W beat that arrives before its
//               write address. Loaded on a W handshake in IDLE, drained when
//               the matching AW is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_write_slave_skid #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    CLK_I,
  input  logic                    RSTN_I,
  input  logic                    load,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    valid,
  output logic [DATA_WIDTH-1:0]   data,
  output logic [DATA_WIDTH/8-1:0] strb,
  output logic                    last
);

  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH/8-1:0] r_strb;
  logic                    r_last;

  // Occupancy flag: load wins over clear (they are never requested together)
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
    end else if (clear) begin
      r_valid <= 1'b0;
    end
  end

  // Beat payload capture
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      r_data <= '0;
      r_strb <= '0;
      r_last <= 1'b0;
    end else if (load) begin
      r_data <= wdata;
      r_strb <= wstrb;
      r_last <= wlast;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;
  assign strb  = r_strb;
  assign last  = r_last;

endmodule : axi_write_slave_skid
`default_nettype wire

// File: rtl/axi_write_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_write_slave
// Description : AXI4 write-channel slave that turns bursts into single-word
//               writes on a local memory port. Supports W data arriving one
//               beat ahead of AW through a one-beat skid buffer. FIXED and
//               INCR bursts write; WRAP/reserved bursts are drained with
//               SLVERR. A WLAST in the wrong place also yields SLVERR.
// Options     : AXI_WRITE_SLAVE_WSTRB_EN - forward WSTRB to WR_STRB_O and
//               suppress writes whose strobe is all zero. When undefined the
//               strobe output is all ones and every legal beat writes.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_write_slave
  import axi_write_slave_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32
) (
  input  logic                            CLK_I,
  input  logic                            RSTN_I,
  // write address channel
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  // write response channel
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  // local memory write port
  output logic                            WR_EN_O,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   WR_ADDR_O,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   WR_DATA_O,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] WR_STRB_O
);

  localparam int C_STRB_WIDTH = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] C_ADDR_ONE =
    {{(C_S_AXI_ADDR_WIDTH-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t                        r_state;
  logic [C_S_AXI_ID_WIDTH-1:0]   r_awid;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_addr;    // address of the next beat
  logic [7:0]                    r_len;
  logic [2:0]                    r_size;
  logic [1:0]                    r_burst;
  logic [7:0]                    r_cnt;     // index of the next beat
  logic                          r_err;     // error seen on an earlier beat
  logic [1:0]                    r_bresp;

  logic                          r_wr_en;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_wr_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_wr_data;
  logic [C_STRB_WIDTH-1:0]       r_wr_strb;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic                          w_in_idle;
  logic                          w_in_data;
  logic                          w_in_resp;
  logic                          w_awready;
  logic                          w_wready;
  logic                          w_aw_hs;
  logic                          w_w_hs;

  logic                          w_skid_valid;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_skid_data;
  logic [C_STRB_WIDTH-1:0]       w_skid_strb;
  logic                          w_skid_last;
  logic                          w_skid_load;
  logic                          w_skid_clear;

  logic                          w_beat_vld;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_b_data;
  logic [C_STRB_WIDTH-1:0]       w_b_strb;
  logic                          w_b_wlast;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_b_addr;
  logic [7:0]                    w_b_len;
  logic [2:0]                    w_b_size;
  logic [1:0]                    w_b_burst;
  logic [7:0]                    w_b_idx;
  logic                          w_err_acc;
  logic                          w_b_last_beat;
  logic                          w_b_err;
  logic                          w_err_total;
  logic                          w_b_write;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_next_addr;

  assign w_in_idle = (r_state == C_ST_IDLE);
  assign w_in_data = (r_state == C_ST_DATA);
  assign w_in_resp = (r_state == C_ST_RESP);

  assign w_awready = w_in_idle;
  assign w_wready  = (w_in_idle & ~w_skid_valid) | w_in_data;

  assign w_aw_hs = S_AXI_AWVALID & w_awready;
  assign w_w_hs  = S_AXI_WVALID & w_wready;

  // A lone W in IDLE is parked; a W together with AW is beat 0 directly.
  assign w_skid_load  = w_in_idle & w_w_hs & ~w_aw_hs;
  assign w_skid_clear = w_aw_hs & w_skid_valid;

  // A beat is processed on every W handshake in DATA, or on AW acceptance
  // when beat 0 is either on the bus or waiting in the skid buffer.
  assign w_beat_vld = (w_aw_hs & (w_w_hs | w_skid_valid)) | (w_in_data & w_w_hs);

  // Select the beat payload and the burst context it belongs to
  always_comb begin
    w_b_data  = w_skid_valid ? w_skid_data : S_AXI_WDATA;
    w_b_strb  = w_skid_valid ? w_skid_strb : S_AXI_WSTRB;
    w_b_wlast = w_skid_valid ? w_skid_last : S_AXI_WLAST;
    if (w_in_idle) begin
      w_b_addr  = S_AXI_AWADDR;
      w_b_len   = S_AXI_AWLEN;
      w_b_size  = S_AXI_AWSIZE;
      w_b_burst = S_AXI_AWBURST;
      w_b_idx   = 8'd0;
      w_err_acc = 1'b0;
    end else begin
      w_b_addr  = r_addr;
      w_b_len   = r_len;
      w_b_size  = r_size;
      w_b_burst = r_burst;
      w_b_idx   = r_cnt;
      w_err_acc = r_err;
    end
  end

  assign w_b_last_beat = (w_b_idx == w_b_len);
  assign w_b_err       = (w_b_wlast != w_b_last_beat) | ~burst_writes(w_b_burst);
  assign w_err_total   = w_err_acc | w_b_err;
  assign w_next_addr   = (w_b_burst == C_BURST_INCR)
                       ? (w_b_addr + (C_ADDR_ONE << w_b_size))
                       : w_b_addr;

`ifdef AXI_WRITE_SLAVE_WSTRB_EN
  assign w_b_write = w_beat_vld & burst_writes(w_b_burst) & (|w_b_strb);
`else
  // Strobes are not forwarded in this build; fold them into a sink so the
  // buffered strobe bits are not left dangling.
  logic w_unused_strb;
  assign w_unused_strb = ^w_b_strb;
  assign w_b_write     = w_beat_vld & burst_writes(w_b_burst);
`endif

  // --------------------------------------------------------------------------
  // Skid buffer
  // --------------------------------------------------------------------------
  axi_write_slave_skid #(
    .DATA_WIDTH (C_S_AXI_DATA_WIDTH)
  ) u_skid (
    .CLK_I  (CLK_I),
    .RSTN_I (RSTN_I),
    .load   (w_skid_load),
    .clear  (w_skid_clear),
    .wdata  (S_AXI_WDATA),
    .wstrb  (S_AXI_WSTRB),
    .wlast  (S_AXI_WLAST),
    .valid  (w_skid_valid),
    .data   (w_skid_data),
    .strb   (w_skid_strb),
    .last   (w_skid_last)
  );

  // Burst FSM: address capture, beat counting, error tracking, response
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      r_state <= C_ST_IDLE;
      r_awid  <= '0;
      r_addr  <= '0;
      r_len   <= 8'd0;
      r_size  <= 3'd0;
      r_burst <= 2'd0;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
      r_bresp <= C_RESP_OKAY;
    end else begin
      case (r_state)
        C_ST_IDLE, C_ST_DATA: begin
          if (w_aw_hs) begin
            r_awid  <= S_AXI_AWID;
            r_len   <= S_AXI_AWLEN;
            r_size  <= S_AXI_AWSIZE;
            r_burst <= S_AXI_AWBURST;
            if (!w_beat_vld) begin
              r_state <= C_ST_DATA;
              r_cnt   <= 8'd0;
              r_addr  <= S_AXI_AWADDR;
              r_err   <= 1'b0;
            end
          end
          if (w_beat_vld) begin
            if (w_b_last_beat) begin
              r_state <= C_ST_RESP;
              r_cnt   <= 8'd0;
              r_err   <= 1'b0;
              r_bresp <= w_err_total ? C_RESP_SLVERR : C_RESP_OKAY;
            end else begin
              r_state <= C_ST_DATA;
              r_cnt   <= w_b_idx + 8'd1;
              r_addr  <= w_next_addr;
              r_err   <= w_err_total;
            end
          end
        end
        C_ST_RESP: begin
          if (S_AXI_BREADY) begin
            r_state <= C_ST_IDLE;
          end
        end
        default: r_state <= C_ST_IDLE;
      endcase
    end
  end

  // Local memory write port: one registered pulse per writing beat
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_strb <= '0;
    end else begin
      r_wr_en <= w_b_write;
      if (w_b_write) begin
        r_wr_addr <= w_b_addr;
        r_wr_data <= w_b_data;
`ifdef AXI_WRITE_SLAVE_WSTRB_EN
        r_wr_strb <= w_b_strb;
`else
        r_wr_strb <= '1;
`endif
      end
    end
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_BVALID  = w_in_resp;
  assign S_AXI_BID     = r_awid;
  assign S_AXI_BRESP   = r_bresp;

  assign WR_EN_O   = r_wr_en;
  assign WR_ADDR_O = r_wr_addr;
  assign WR_DATA_O = r_wr_data;
  assign WR_STRB_O = r_wr_strb;

endmodule : axi_write_slave
`default_nettype wire
